// File: rtl/useq_sequencer.sv
// ---------------------------------------------------------------------------
// useq_sequencer -- microcode address sequencer with a 16-deep return stack.
//
// Ports:
//   clk       microcode clock, rising edge
//   rst_n     asynchronous active-low reset
//   clken     microcycle enable; nothing but clrERR acts while low
//   cromJ     [0:11] microword J field (base next address)
//   dispADDR  [0:11] dispatch address, 0 when no dispatch
//   skip      skip condition, ORed into next-address bit 11
//   cromCALL  push current microaddress
//   cromRET   pop return stack
//   pageFail  page-fail trap: jump to 3777 and push current address
//   clrERR    synchronous clear of sticky stack error flags
//   addr      [0:11] registered current microaddress
//   dispRET   [0:11] top-of-stack entry, 0 when empty
//   depth     stack occupancy 0..16
//   stkOVF    sticky overflow flag
//   stkUNF    sticky underflow flag
// Bit 0 is the MSB, bit 11 the LSB.
// ---------------------------------------------------------------------------
module useq_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clken,
  input  logic [0:11] cromJ,
  input  logic [0:11] dispADDR,
  input  logic        skip,
  input  logic        cromCALL,
  input  logic        cromRET,
  input  logic        pageFail,
  input  logic        clrERR,
  output logic [0:11] addr,
  output logic [0:11] dispRET,
  output logic [4:0]  depth,
  output logic        stkOVF,
  output logic        stkUNF
);

  localparam logic [0:11] TrapAddr = 12'o3777;

  // Packed so an overflow shift is a single slice/concatenation:
  // stack[0] is the oldest entry.
  logic [0:15][0:11] stack;

  logic [0:11] nextAddr;
  logic [4:0]  depthM1;
  logic        full;
  logic        empty;
  logic        doPush;
  logic        doPop;
  logic        doReplace;
  logic        ovfSet;
  logic        unfSet;

  always_comb begin
    nextAddr  = '0;
    depthM1   = depth - 5'd1;
    full      = (depth == 5'd16);
    empty     = (depth == 5'd0);
    doPush    = 1'b0;
    doPop     = 1'b0;
    doReplace = 1'b0;

    if (pageFail) begin
      nextAddr = TrapAddr;
    end else begin
      nextAddr = cromJ | dispADDR | {11'b0, skip};
    end

    if (clken) begin
      if (pageFail) begin
        doPush = 1'b1;
      end else if (cromCALL && cromRET) begin
        // CALL+RET on an empty stack degenerates to a plain push.
        if (empty) doPush    = 1'b1;
        else       doReplace = 1'b1;
      end else if (cromCALL) begin
        doPush = 1'b1;
      end else if (cromRET) begin
        doPop = 1'b1;
      end
    end

    ovfSet = doPush && full;
    unfSet = doPop && empty;

    dispRET = empty ? '0 : stack[depthM1[3:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      depth  <= '0;
      stkOVF <= 1'b0;
      stkUNF <= 1'b0;
    end else begin
      if (clken) begin
        addr <= nextAddr;
        if (doPush && !full)  depth <= depth + 5'd1;
        if (doPop  && !empty) depth <= depthM1;
      end
      stkOVF <= ovfSet | (stkOVF & ~clrERR);
      stkUNF <= unfSet | (stkUNF & ~clrERR);
    end
  end

  // Stack storage needs no reset: depth gates every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      if (full) stack <= {stack[1:15], addr};
      else      stack[depth[3:0]] <= addr;
    end else if (doReplace) begin
      stack[depthM1[3:0]] <= addr;
    end
  end

endmodule

// File: doc/useq_sequencer.md
USEQ_SEQUENCER -- requirements
Module: useq_sequencer

Interface
REQ-001 clk  input  1  microcode clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 clken  input  1  microcycle enable; no state change when 0.
REQ-004 cromJ  input  12 [0:11]  microword J field, the base next address.
REQ-005 dispADDR  input  12 [0:11]  dispatch address from the dispatch mux; 0 when no dispatch.
REQ-006 skip  input  1  skip condition, ORed into next-address bit 11.
REQ-007 cromCALL  input  1  push the current microaddress onto the return stack.
REQ-008 cromRET  input  1  pop the return stack.
REQ-009 pageFail  input  1  page-fail trap request.
REQ-010 clrERR  input  1  synchronous clear of the sticky error flags.
REQ-011 addr  output  12 [0:11]  registered current microaddress to the CROM.
REQ-012 dispRET  output  12 [0:11]  top-of-stack entry; 12'o0000 when the stack is empty.
REQ-013 depth  output  5  stack occupancy, 0..16.
REQ-014 stkOVF  output  1  sticky overflow flag.
REQ-015 stkUNF  output  1  sticky underflow flag.

Function
REQ-016 Next address (normal) = cromJ | dispADDR, with bit 11 additionally ORed with skip; loaded into addr on clk when clken=1.
REQ-017 Latency: addr updates one clock after a clken=1 cycle; dispRET and depth reflect the push/pop of that same edge.
REQ-018 pageFail=1 with clken=1: next address = 12'o3777 (overrides REQ-016); current addr is pushed; cromCALL and cromRET are ignored in that cycle.
REQ-019 Return stack: 16 entries x 12 bits, LIFO; dispRET = entry[depth-1], combinational from the stored state.
REQ-020 CALL only: push addr; depth +1.
REQ-021 RET only: pop; depth -1.
REQ-022 CALL and RET in the same cycle: replace the top entry with addr; depth unchanged.
REQ-023 CALL and RET in the same cycle at depth 0: push only; depth becomes 1; stkUNF is not set.
REQ-024 Push at depth 16:
- depth stays 16.
- The oldest entry is discarded; the stack shifts down.
- The new entry becomes the top.
- stkOVF is set.
REQ-025 Pop at depth 0: depth stays 0; dispRET stays 0; stkUNF is set.
REQ-026 stkOVF and stkUNF stay set until clrERR=1 or reset.
REQ-027 Flag set and clrERR in the same cycle: the set wins.
REQ-028 clrERR acts regardless of clken.
REQ-029 clken=0: addr, stack contents, depth and flags all hold, except clrERR per REQ-028.
REQ-030 Address arithmetic is a pure 12-bit OR; there is no carry and no increment.

Reset
REQ-031 rst_n low forces, asynchronously: addr=12'o0000, depth=0, stkOVF=0, stkUNF=0, dispRET=12'o0000.
REQ-032 Stack RAM contents after reset are don't-care, but are never visible because depth=0.
REQ-033 Reset asserted mid-operation discards all stack state immediately.
REQ-034 After rst_n deasserts, the first clken=1 edge loads the REQ-016 address.

Verification
REQ-035 Basic next-address:
- Stimulus: cromJ=12'o0100, dispADDR=12'o0005, skip=1.
- Response: addr=12'o0105 after one clken edge.
REQ-036 Call/return:
- Stimulus: at addr=12'o0200, CALL with cromJ=12'o0400; next cycle RET.
- Response: dispRET=12'o0200 and depth=1 after the CALL; depth=0 after the RET.
REQ-037 Overflow:
- Stimulus: 17 consecutive CALLs from addresses 1..17.
- Response: depth=16, stkOVF=1, dispRET=17; 16 pops yield 17 down to 2; stkUNF=0.
REQ-038 Underflow and flag clear:
- Stimulus: RET at depth 0, then clrERR.
- Response: stkUNF=1 and dispRET=0 after the RET; stkUNF=0 after clrERR.
REQ-039 Page fail:
- Stimulus: pageFail together with CALL and RET at addr=12'o0321.
- Response: addr=12'o3777, dispRET=12'o0321, depth +1.
REQ-040 Async reset mid-run:
- Stimulus: rst_n low with no clock edge while depth=5.
- Response: addr=0, depth=0, flags=0, all immediately.
